// File: rtl/tri_assembly_ctrl_if.sv
// Vertex stream and rasterizer handshake bundle for tri_assembly_ctrl.
// master = the controller side, slave = vertex source plus rasterizer.
interface tri_assembly_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              vtx_valid;
  logic              vtx_ready;
  logic [DATA_W-1:0] vtx_x;
  logic [DATA_W-1:0] vtx_y;
  logic              vtx_eop;

  logic              rast_start;
  logic [DATA_W-1:0] rast_v0_x;
  logic [DATA_W-1:0] rast_v0_y;
  logic [DATA_W-1:0] rast_v1_x;
  logic [DATA_W-1:0] rast_v1_y;
  logic [DATA_W-1:0] rast_v2_x;
  logic [DATA_W-1:0] rast_v2_y;
  logic              rast_done;

  modport master (
    input  vtx_valid, vtx_x, vtx_y, vtx_eop, rast_done,
    output vtx_ready, rast_start,
           rast_v0_x, rast_v0_y, rast_v1_x, rast_v1_y, rast_v2_x, rast_v2_y
  );

  modport slave (
    output vtx_valid, vtx_x, vtx_y, vtx_eop, rast_done,
    input  vtx_ready, rast_start,
           rast_v0_x, rast_v0_y, rast_v1_x, rast_v1_y, rast_v2_x, rast_v2_y
  );
endinterface

// File: rtl/tri_assembly_ctrl.sv
// Triangle assembler: gathers list/strip vertices, issues one triangle at a
// time to the rasterizer, waits for done under a watchdog, keeps debug counters.
module tri_assembly_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  tri_assembly_ctrl_if.master bus,
  output logic                busy,
  output logic [CNT_W-1:0]    tri_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                timeout_err
);
  localparam int               WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_COLLECT, ST_ISSUE, ST_WAIT} state_e;
  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } vtx_t;

  state_e           state_q, state_d;
  logic [1:0]       vcnt_q, vcnt_d;      // 3 = strip window full
  logic             parity_q, parity_d;
  logic             mode_q, mode_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] tri_cnt_q, tri_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  vtx_t             win_q [3];
  vtx_t             win_d [3];
  vtx_t             tri_q [3];
  vtx_t             tri_d [3];

  logic accept;
  logic strip;
  vtx_t in_vtx;

  // NOTE: every _d gets its current value first so no path through the case leaves a latch.
  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    parity_d   = parity_q;
    mode_d     = mode_q;
    err_d      = err_q;
    wd_d       = wd_q;
    tri_cnt_d  = tri_cnt_q;
    drop_cnt_d = drop_cnt_q;
    win_d      = win_q;
    tri_d      = tri_q;
    in_vtx     = vtx_t'{x: bus.vtx_x, y: bus.vtx_y};
    accept     = bus.vtx_valid & ready_q;
    strip      = (vcnt_q == 2'd0) ? mode : mode_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (vcnt_q == 2'd0) mode_d = mode;
          unique case (vcnt_q)
            2'd0: win_d[0] = in_vtx;
            2'd1: win_d[1] = in_vtx;
            2'd2: win_d[2] = in_vtx;
            default: begin
              win_d[0] = win_q[1];
              win_d[1] = win_q[2];
              win_d[2] = in_vtx;
            end
          endcase
          if (vcnt_q[1]) begin
            state_d = ST_ISSUE;
            tri_d   = win_d;
            // Odd strip triangles swap the first two vertices to keep winding.
            if (strip && parity_q) begin
              tri_d[0] = win_d[1];
              tri_d[1] = win_d[0];
            end
            if (bus.vtx_eop) begin
              vcnt_d   = 2'd0;
              parity_d = 1'b0;
            end else if (strip) begin
              vcnt_d   = 2'd3;
              parity_d = ~parity_q;
            end else begin
              vcnt_d = 2'd0;
            end
          end else if (bus.vtx_eop) begin
            vcnt_d   = 2'd0;
            parity_d = 1'b0;
            if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
          end else begin
            vcnt_d = vcnt_q + 2'd1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT: begin
        if (bus.rast_done) begin
          state_d = ST_COLLECT;
          if (tri_cnt_q != CNT_MAX) tri_cnt_d = tri_cnt_q + 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_COLLECT;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    ready_d = (state_d == ST_COLLECT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the vertex window and triangle registers are reset too, since they drive outputs that must read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_COLLECT;
      vcnt_q     <= 2'd0;
      parity_q   <= 1'b0;
      mode_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
      tri_cnt_q  <= '0;
      drop_cnt_q <= '0;
      win_q      <= '{default: '0};
      tri_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      parity_q   <= parity_d;
      mode_q     <= mode_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      tri_cnt_q  <= tri_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      win_q      <= win_d;
      tri_q      <= tri_d;
    end
  end

  assign bus.vtx_ready  = ready_q;
  assign bus.rast_start = (state_q == ST_ISSUE);
  assign bus.rast_v0_x  = tri_q[0].x;
  assign bus.rast_v0_y  = tri_q[0].y;
  assign bus.rast_v1_x  = tri_q[1].x;
  assign bus.rast_v1_y  = tri_q[1].y;
  assign bus.rast_v2_x  = tri_q[2].x;
  assign bus.rast_v2_y  = tri_q[2].y;
  assign busy           = (state_q != ST_COLLECT);
  assign tri_count      = tri_cnt_q;
  assign drop_count     = drop_cnt_q;
  assign timeout_err    = err_q;
endmodule

// File: tb/tb_tri_assembly_ctrl.sv
// Scenario bench for tri_assembly_ctrl: a rasterizer responder records every
// issued triangle, tasks compare them against triangles queued at stimulus time.
module tb_tri_assembly_ctrl;
  typedef struct packed {
    logic [31:0] x0, y0, x1, y1, x2, y2;
  } tri_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       busy;
  logic [1:0] tri_count;
  logic [1:0] drop_count;
  logic       timeout_err;

  tri_assembly_ctrl_if #(.DATA_W(32)) bus ();

  tri_assembly_ctrl #(.DATA_W(32), .CNT_W(2), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .bus         (bus),
    .busy        (busy),
    .tri_count   (tri_count),
    .drop_count  (drop_count),
    .timeout_err (timeout_err)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_delay = 3;
  int   timer = -1;
  logic force_done = 1'b0;
  int   exp_tri = 0;
  int   exp_drop = 0;
  tri_t exp_q[$];
  tri_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Rasterizer model: records each start, answers with done after done_delay cycles.
  always @(negedge clk) begin
    bus.rast_done = force_done;
    if (timer > 0) begin
      timer = timer - 1;
      if (timer == 0) begin
        bus.rast_done = 1'b1;
        timer = -1;
      end
    end
    if (bus.rast_start === 1'b1) begin
      obs_q.push_back(tri_t'{bus.rast_v0_x, bus.rast_v0_y, bus.rast_v1_x,
                             bus.rast_v1_y, bus.rast_v2_x, bus.rast_v2_y});
      if (done_delay > 0) timer = done_delay;
    end
  end

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic tri_t mk(input int a0, b0, a1, b1, a2, b2);
    return tri_t'{32'(a0), 32'(b0), 32'(a1), 32'(b1), 32'(a2), 32'(b2)};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic send_vtx(input int x, input int y, input logic eop);
    int n = 0;
    bus.vtx_valid = 1'b1;
    bus.vtx_x     = 32'(x);
    bus.vtx_y     = 32'(y);
    bus.vtx_eop   = eop;
    while (bus.vtx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("FAIL send_vtx: vtx_ready=%b after %0d cycles, required 1", bus.vtx_ready, n);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.vtx_valid = 1'b0;
    bus.vtx_eop   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ((|{bus.vtx_ready, bus.rast_start, busy, tri_count, drop_count, timeout_err,
           bus.rast_v0_x, bus.rast_v2_y}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b start=%b busy=%b tri=%0d drop=%0d err=%b, required all 0",
               bus.vtx_ready, bus.rast_start, busy, tri_count, drop_count, timeout_err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: vtx_ready=%b, required 1", bus.vtx_ready);
    end
  endtask

  task automatic test_list();
    int   n = 0;
    tri_t e, o;
    mode = 1'b0;
    done_delay = 3;
    exp_q.push_back(mk(1, 1, 2, 2, 3, 3));
    exp_q.push_back(mk(4, 4, 5, 5, 6, 6));
    for (int i = 1; i <= 6; i++) begin
      send_vtx(i, i, 1'b0);
      if (i % 3 == 0) begin
        checks++;
        if (bus.rast_start !== 1'b1) begin
          errors++;
          $display("FAIL list_latency: rast_start=%b after vertex %0d, required 1", bus.rast_start, i);
        end
      end
    end
    idle(0);
    while ((obs_q.size() < exp_q.size() || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL list_starts: starts=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL list_tri: got %h, required %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    exp_tri = sat(exp_tri + 2);
    checks++;
    if (tri_count !== 2'(exp_tri)) begin
      errors++;
      $display("FAIL list_tri_count: tri_count=%0d, required %0d", tri_count, exp_tri);
    end
  endtask

  task automatic test_strip();
    int   n = 0;
    tri_t e, o;
    mode = 1'b1;
    done_delay = 3;
    exp_q.push_back(mk(10, 0, 20, 0, 30, 0));
    exp_q.push_back(mk(30, 0, 20, 0, 40, 0));
    exp_q.push_back(mk(30, 0, 40, 0, 50, 0));
    for (int i = 1; i <= 5; i++) send_vtx(i * 10, 0, i == 5);
    idle(0);
    mode = 1'b0;
    while ((obs_q.size() < exp_q.size() || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL strip_starts: starts=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL strip_tri: got %h, required %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    exp_tri = sat(exp_tri + 3);
    checks++;
    if (tri_count !== 2'(exp_tri)) begin
      errors++;
      $display("FAIL strip_tri_count: tri_count=%0d, required %0d (saturating)", tri_count, exp_tri);
    end
  endtask

  task automatic test_eop_drop();
    int   n = 0;
    tri_t e, o;
    mode = 1'b0;
    done_delay = 3;
    send_vtx(61, 1, 1'b0);
    send_vtx(62, 2, 1'b1);
    idle(5);
    exp_drop = sat(exp_drop + 1);
    checks++;
    if (obs_q.size() != 0 || drop_count !== 2'(exp_drop)) begin
      errors++;
      $display("FAIL drop_partial: starts=%0d drop_count=%0d, required 0 and %0d",
               obs_q.size(), drop_count, exp_drop);
    end
    // Mode flips mid-group must not turn this list triangle into a strip.
    exp_q.push_back(mk(63, 3, 64, 4, 65, 5));
    send_vtx(63, 3, 1'b0);
    mode = 1'b1;
    send_vtx(64, 4, 1'b0);
    send_vtx(65, 5, 1'b0);
    idle(0);
    mode = 1'b0;
    while ((obs_q.size() < exp_q.size() || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    send_vtx(66, 6, 1'b1);
    idle(5);
    exp_drop = sat(exp_drop + 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drop_restart_starts: starts=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drop_restart_tri: got %h, required %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    exp_tri = sat(exp_tri + 1);
    checks++;
    if (drop_count !== 2'(exp_drop) || tri_count !== 2'(exp_tri)) begin
      errors++;
      $display("FAIL drop_counts: drop=%0d tri=%0d, required %0d and %0d",
               drop_count, tri_count, exp_drop, exp_tri);
    end
  endtask

  task automatic test_back_to_back();
    int   n = 0;
    int   lo;
    tri_t e, o;
    mode = 1'b0;
    done_delay = 5;
    exp_q.push_back(mk(100, 200, 101, 201, 102, 202));
    exp_q.push_back(mk(103, 203, 104, 204, 105, 205));
    for (int i = 0; i < 6; i++) begin
      send_vtx(100 + i, 200 + i, 1'b0);
      if (i == 2) begin
        lo = 0;
        while (bus.vtx_ready !== 1'b1 && lo < 50) begin
          lo++;
          @(negedge clk);
        end
        checks++;
        if (lo != 6) begin
          errors++;
          $display("FAIL b2b_ready_low: vtx_ready low for %0d cycles, required 6", lo);
        end
      end
    end
    idle(0);
    while ((obs_q.size() < exp_q.size() || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_starts: starts=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_tri: got %h, required %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturation();
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_vtx(70 + i, 0, 1'b1);
      idle(1);
      exp_drop = sat(exp_drop + 1);
      checks++;
      if (drop_count !== 2'(exp_drop)) begin
        errors++;
        $display("FAIL drop_saturate: drop_count=%0d, required %0d", drop_count, exp_drop);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL drop_no_start: starts=%0d, required 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    int s;
    int n = 0;
    mode = 1'b0;
    done_delay = -1;
    send_vtx(7, 7, 1'b0);
    send_vtx(8, 8, 1'b0);
    send_vtx(9, 9, 1'b0);
    s = cyc;
    idle(0);
    checks++;
    if (bus.rast_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: rast_start=%b, required 1", bus.rast_start);
    end
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc - s != 16) begin
      errors++;
      $display("FAIL timeout_time: timeout_err=%b at %0d cycles after start, required 1 at 16",
               timeout_err, cyc - s);
    end
    @(negedge clk);
    checks++;
    if (bus.vtx_ready !== 1'b1 || busy !== 1'b0 || tri_count !== 2'(exp_tri) || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after: ready=%b busy=%b tri=%0d err=%b, required 1 0 %0d 1",
               bus.vtx_ready, busy, tri_count, timeout_err, exp_tri);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    mode = 1'b0;
    done_delay = -1;
    send_vtx(11, 1, 1'b0);
    send_vtx(12, 2, 1'b0);
    send_vtx(13, 3, 1'b0);
    idle(1);
    obs_q.delete();
    checks++;
    if (busy !== 1'b1 || bus.rast_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: busy=%b start=%b, required 1 0", busy, bus.rast_start);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ((|{bus.vtx_ready, bus.rast_start, busy, tri_count, drop_count, timeout_err,
           bus.rast_v0_x, bus.rast_v0_y, bus.rast_v1_x, bus.rast_v1_y,
           bus.rast_v2_x, bus.rast_v2_y}) !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b start=%b busy=%b tri=%0d drop=%0d err=%b v0x=%h, required all 0",
               bus.vtx_ready, bus.rast_start, busy, tri_count, drop_count, timeout_err, bus.rast_v0_x);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_ready: vtx_ready=%b, required 1", bus.vtx_ready);
    end
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tri_count !== 2'd0 || busy !== 1'b0 || obs_q.size() != 0 || bus.vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_stale_done: tri=%0d busy=%b starts=%0d ready=%b, required 0 0 0 1",
               tri_count, busy, obs_q.size(), bus.vtx_ready);
    end
  endtask

  initial begin
    bus.vtx_valid = 1'b0;
    bus.vtx_x     = '0;
    bus.vtx_y     = '0;
    bus.vtx_eop   = 1'b0;
    test_reset();
    test_list();
    test_strip();
    test_eop_drop();
    test_back_to_back();
    test_saturation();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench time limit reached");
  end
endmodule
